sysid_read_master: RTL and testbench

SYSID_READ_MASTER -- requirements
Module: sysid_read_master

---
 rtl/sysid_read_master.sv | 204 ++++++++++++++++++++
 tb/tb_sysid_read_master.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_read_master.sv
// Reads the system-ID block through an Avalon-MM master port: word 1 (ID),
// then word 0 (timestamp), then compares both against the expected values.
// Each read attempt is bounded by a cycle budget and may be retried after a
// timeout. Results are held as sticky status flags until the next sequence.
//
// Handshake: the master raises read with a stable address and holds both
// until a cycle with read=1 and waitrequest=0 (command accepted). Data is
// taken only on a cycle with readdatavalid=1 that belongs to the accepted
// command: the acceptance cycle itself, or a later WAIT-state cycle.
// At most one read is outstanding; readdatavalid is ignored in any other
// state, including the one-cycle retry gap.
module sysid_read_master #(
    parameter logic [31:0] EXPECTED_ID    = 32'h619F_5ABF,
    parameter logic [31:0] EXPECTED_TS    = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        address,
    output logic        read,
    input  logic        waitrequest,
    input  logic        readdatavalid,
    input  logic [31:0] readdata,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        err_mismatch,
    output logic        err_timeout,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ID_REQ  = 3'd1,
        S_ID_WAIT = 3'd2,
        S_TS_REQ  = 3'd3,
        S_TS_WAIT = 3'd4,
        S_CHECK   = 3'd5
    } state_t;

    // The attempt counter starts at 0 on the first cycle of an attempt, so an
    // attempt that has not captured by count TIMEOUT_CYCLES-1 has used its budget.
    localparam logic [15:0] CNT_LAST  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRIES);

    state_t      state_q, state_d;
    logic        gap_q, gap_d;        // one read-low cycle before a retry
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic        addr_q, addr_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        done_q, done_d;
    logic        id_ok_q, id_ok_d;
    logic        mism_q, mism_d;
    logic        tmo_q, tmo_d;
    logic        auto_q, auto_d;      // pending auto-start after reset release

    logic in_req;
    logic in_wait;
    logic is_id;
    logic read_int;
    logic accept;
    logic capture;
    logic timeout;
    logic match;

    assign in_req   = (state_q == S_ID_REQ) || (state_q == S_TS_REQ);
    assign in_wait  = (state_q == S_ID_WAIT) || (state_q == S_TS_WAIT);
    assign is_id    = (state_q == S_ID_REQ) || (state_q == S_ID_WAIT);
    assign read_int = in_req && !gap_q;
    assign accept   = read_int && !waitrequest;
    assign capture  = (accept || in_wait) && readdatavalid;
    // Capture takes priority: a response on the last budgeted cycle still counts.
    assign timeout  = (in_req || in_wait) && !gap_q && (cnt_q == CNT_LAST) && !capture;
    assign match    = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);

    // Next-state, counters, capture and status flag logic.
    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        addr_d  = addr_q;
        id_d    = id_q;
        ts_d    = ts_q;
        done_d  = done_q;
        id_ok_d = id_ok_q;
        mism_d  = mism_q;
        tmo_d   = tmo_q;
        auto_d  = auto_q;

        case (state_q)
            S_IDLE: begin
                if (start || auto_q) begin
                    state_d = S_ID_REQ;
                    auto_d  = 1'b0;
                    addr_d  = 1'b1;
                    gap_d   = 1'b0;
                    cnt_d   = '0;
                    retry_d = '0;
                    done_d  = 1'b0;
                    id_ok_d = 1'b0;
                    mism_d  = 1'b0;
                    tmo_d   = 1'b0;
                end
            end

            S_ID_REQ, S_ID_WAIT, S_TS_REQ, S_TS_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (gap_q) begin
                    // Gap cycle: read is low; the next attempt starts fresh.
                    gap_d = 1'b0;
                    cnt_d = '0;
                end else if (capture) begin
                    if (is_id) begin
                        id_d    = readdata;
                        state_d = S_TS_REQ;
                        addr_d  = 1'b0;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        ts_d    = readdata;
                        state_d = S_CHECK;
                    end
                end else if (timeout) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 4'd1;
                        gap_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = is_id ? S_ID_REQ : S_TS_REQ;
                    end else begin
                        // Out of retries: abandon the sequence, skipping any TS read.
                        tmo_d   = 1'b1;
                        done_d  = 1'b1;
                        id_ok_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (accept) begin
                    state_d = is_id ? S_ID_WAIT : S_TS_WAIT;
                end
            end

            S_CHECK: begin
                id_ok_d = match;
                mism_d  = !match;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gap_q   <= 1'b0;
            cnt_q   <= '0;
            retry_q <= '0;
            addr_q  <= 1'b0;
            id_q    <= '0;
            ts_q    <= '0;
            done_q  <= 1'b0;
            id_ok_q <= 1'b0;
            mism_q  <= 1'b0;
            tmo_q   <= 1'b0;
            auto_q  <= AUTO_START;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            cnt_q   <= cnt_d;
            retry_q <= retry_d;
            addr_q  <= addr_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            done_q  <= done_d;
            id_ok_q <= id_ok_d;
            mism_q  <= mism_d;
            tmo_q   <= tmo_d;
            auto_q  <= auto_d;
        end
    end

    assign read         = read_int;
    assign address      = addr_q;
    assign id_value     = id_q;
    assign ts_value     = ts_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign id_ok        = id_ok_q;
    assign err_mismatch = mism_q;
    assign err_timeout  = tmo_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_sysid_read_master.sv
// Bench for sysid_read_master: DUT A (default parameters) talks to a
// behavioural slave with random stalls/latency/data; DUT B (short timeout,
// one retry) talks to a slave that never completes a read.
module tb_sysid_read_master;

    localparam logic [31:0] EXP_ID = 32'h619F_5ABF;
    localparam logic [31:0] EXP_TS = 32'h0000_0000;
    localparam int B_T = 4;
    localparam int B_R = 1;
    localparam int ITERS = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n = 1'b0;

    // ---------------- DUT A signals ----------------
    logic        start_a = 1'b0;
    logic        address_a, read_a;
    logic        wr_a = 1'b1;
    logic        rdv_a = 1'b0;
    logic [31:0] rd_a = '0;
    logic [31:0] id_a, ts_a;
    logic        busy_a, done_a, ok_a, mism_a, tmo_a;
    logic [2:0]  st_a;

    // ---------------- DUT B signals ----------------
    logic        start_b = 1'b0;
    logic        address_b, read_b;
    logic        wr_b, rdv_b;
    logic [31:0] rd_b = '0;
    logic [31:0] id_b, ts_b;
    logic        busy_b, done_b, ok_b, mism_b, tmo_b;
    logic [2:0]  st_b;
    int          b_mode = 0;   // 0: waitrequest stuck high, 1: accepts but never answers

    assign wr_b  = (b_mode == 0);
    assign rdv_b = 1'b0;

    sysid_read_master dut_a (
        .clock(clk), .reset_n(rst_n), .start(start_a),
        .address(address_a), .read(read_a), .waitrequest(wr_a),
        .readdatavalid(rdv_a), .readdata(rd_a),
        .id_value(id_a), .ts_value(ts_a), .busy(busy_a), .done(done_a),
        .id_ok(ok_a), .err_mismatch(mism_a), .err_timeout(tmo_a),
        .dbg_state(st_a)
    );

    sysid_read_master #(.TIMEOUT_CYCLES(B_T), .MAX_RETRIES(B_R)) dut_b (
        .clock(clk), .reset_n(rst_n), .start(start_b),
        .address(address_b), .read(read_b), .waitrequest(wr_b),
        .readdatavalid(rdv_b), .readdata(rd_b),
        .id_value(id_b), .ts_value(ts_b), .busy(busy_b), .done(done_b),
        .id_ok(ok_b), .err_mismatch(mism_b), .err_timeout(tmo_b),
        .dbg_state(st_b)
    );

    // ---------------- slave A model ----------------
    logic [31:0] mem0 = EXP_TS, mem1 = EXP_ID;
    int          stall_id = 0, stall_ts = 0, lat_id = 0, lat_ts = 0;
    logic        stray_en = 1'b0;

    logic        pend = 1'b0, in_req = 1'b0, prev_stall = 1'b0, prev_addr = 1'b0;
    int          lat_left = 0, stall_left = 0, lat = 0;
    logic [31:0] pend_data = '0;
    int          acc_cnt = 0;
    logic        acc_addr [0:255];
    int          stab_err = 0;

    // Slave responds a little after each rising edge so the DUT sees stable inputs.
    always begin
        @(posedge clk);
        #2;
        if (rst_n && prev_stall && !(read_a === 1'b1 && address_a === prev_addr))
            stab_err++;
        rdv_a = 1'b0;
        wr_a  = 1'b1;
        rd_a  = $urandom;
        if (!rst_n) begin
            pend   = 1'b0;
            in_req = 1'b0;
        end else if (pend) begin
            if (lat_left == 0) begin
                rdv_a = 1'b1;
                rd_a  = pend_data;
                pend  = 1'b0;
            end else begin
                lat_left--;
            end
        end else if (read_a === 1'b1) begin
            if (!in_req) begin
                in_req     = 1'b1;
                stall_left = address_a ? stall_id : stall_ts;
            end
            if (stall_left > 0) begin
                stall_left--;
            end else begin
                wr_a   = 1'b0;
                in_req = 1'b0;
                acc_addr[acc_cnt[7:0]] = address_a;
                acc_cnt++;
                lat = address_a ? lat_id : lat_ts;
                if (lat == 0) begin
                    rdv_a = 1'b1;
                    rd_a  = address_a ? mem1 : mem0;
                end else begin
                    pend      = 1'b1;
                    lat_left  = lat - 1;
                    pend_data = address_a ? mem1 : mem0;
                end
            end
        end
        if (stray_en) begin
            rdv_a = 1'b1;
            rd_a  = 32'hDEAD_BEEF;
        end
        prev_stall = rst_n && (read_a === 1'b1) && wr_a;
        prev_addr  = address_a;
    end

    // ---------------- monitor B ----------------
    int   b_busy = 0, b_rdhi = 0, b_rise = 0, b_low = 0, b_acc = 0, b_addr0 = 0;
    logic prev_rd_b = 1'b0;

    always begin
        @(posedge clk);
        #2;
        rd_b = $urandom;
        if (busy_b) b_busy++;
        if (read_b) b_rdhi++;
        if (read_b && !prev_rd_b) b_rise++;
        if (busy_b && !read_b) b_low++;
        if (read_b && !wr_b) b_acc++;
        if (read_b && !address_b) b_addr0++;
        prev_rd_b = read_b;
    end

    // ---------------- scoreboard ----------------
    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_idle_a(input int limit, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!busy_a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_reads_a(input int base);
        check("acc_count", 32'(acc_cnt - base), 32'd2);
        for (int k = 0; k < 2; k++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            check("acc_addr", 32'(acc_addr[8'(base + k)]), e);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int          n, base, bb_busy, bb_rdhi, bb_rise, bb_low, bb_acc, bb_addr0;
        logic        ok, exp_ok;
        logic [31:0] last_id, last_ts;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_read", 32'(read_a), 32'd0);
        check("rst_address", 32'(address_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_flags", {28'd0, done_a, ok_a, mism_a, tmo_a}, 32'd0);
        check("rst_id", id_a, 32'd0);
        check("rst_ts", ts_a, 32'd0);
        check("rst_read_b", 32'(read_b), 32'd0);

        // Auto-start after reset release, zero-latency slave
        base = acc_cnt;
        bb_busy = b_busy; bb_rdhi = b_rdhi; bb_rise = b_rise;
        bb_low = b_low; bb_acc = b_acc; bb_addr0 = b_addr0;
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (!busy_a) break;
        end
        check("auto_idle_within_6", 32'(n <= 6), 32'd1);
        check("auto_done", 32'(done_a), 32'd1);
        check("auto_id_ok", 32'(ok_a), 32'd1);
        check("auto_mismatch", 32'(mism_a), 32'd0);
        check("auto_timeout", 32'(tmo_a), 32'd0);
        check("auto_id_value", id_a, EXP_ID);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        check_reads_a(base);

        // DUT B, waitrequest stuck high: (R+1) attempts of T cycles, R gaps
        repeat (12) @(negedge clk);
        check("b0_busy_cycles", 32'(b_busy - bb_busy), 32'((B_R + 1) * B_T + B_R));
        check("b0_read_cycles", 32'(b_rdhi - bb_rdhi), 32'((B_R + 1) * B_T));
        check("b0_attempts", 32'(b_rise - bb_rise), 32'(B_R + 1));
        check("b0_gap_cycles", 32'(b_low - bb_low), 32'(B_R));
        check("b0_addr0_reads", 32'(b_addr0 - bb_addr0), 32'd0);
        check("b0_flags", {27'd0, busy_b, done_b, ok_b, mism_b, tmo_b}, 32'b01001);

        // DUT B, accepted but never answered
        b_mode = 1;
        bb_busy = b_busy; bb_rdhi = b_rdhi; bb_acc = b_acc; bb_addr0 = b_addr0;
        @(negedge clk) start_b = 1'b1;
        @(negedge clk) start_b = 1'b0;
        check("b1_flags_cleared", {27'd0, busy_b, done_b, ok_b, mism_b, tmo_b}, 32'b10000);
        repeat (14) @(negedge clk);
        check("b1_busy_cycles", 32'(b_busy - bb_busy), 32'((B_R + 1) * B_T + B_R));
        check("b1_read_cycles", 32'(b_rdhi - bb_rdhi), 32'(B_R + 1));
        check("b1_accepts", 32'(b_acc - bb_acc), 32'(B_R + 1));
        check("b1_addr0_reads", 32'(b_addr0 - bb_addr0), 32'd0);
        check("b1_flags", {27'd0, busy_b, done_b, ok_b, mism_b, tmo_b}, 32'b01001);
        check("b1_id_untouched", id_b, 32'd0);

        // Randomized sequences on DUT A
        for (int it = 0; it < ITERS; it++) begin
            stall_id = $urandom_range(0, 3);
            stall_ts = $urandom_range(0, 3);
            lat_id   = $urandom_range(0, 3);
            lat_ts   = $urandom_range(0, 3);
            mem1     = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
            mem0     = ($urandom_range(0, 3) == 0) ? $urandom : EXP_TS;
            if (it == 0) begin
                stall_id = 5; lat_id = 0; mem1 = EXP_ID; mem0 = EXP_TS;
            end
            if (it == 1) begin
                mem1 = 32'h1234_5678; mem0 = EXP_TS;
            end
            exp_ok = (mem1 == EXP_ID) && (mem0 == EXP_TS);
            base = acc_cnt;
            exp_q.push_back(32'd1);
            exp_q.push_back(32'd0);

            @(negedge clk) start_a = 1'b1;
            @(negedge clk) start_a = 1'b0;
            check("start_busy", 32'(busy_a), 32'd1);
            check("start_clears", {28'd0, done_a, ok_a, mism_a, tmo_a}, 32'd0);
            // A start while busy must be ignored
            @(negedge clk) start_a = 1'b1;
            @(negedge clk) start_a = 1'b0;
            wait_idle_a(60, ok);
            check("seq_finished", 32'(ok), 32'd1);
            check("seq_done", 32'(done_a), 32'd1);
            check("seq_id_ok", 32'(ok_a), 32'(exp_ok));
            check("seq_mismatch", 32'(mism_a), 32'(!exp_ok));
            check("seq_timeout", 32'(tmo_a), 32'd0);
            check("seq_id_value", id_a, mem1);
            check("seq_ts_value", ts_a, mem0);
            repeat (3) @(negedge clk);
            check("busy_start_ignored", 32'(busy_a), 32'd0);
            check_reads_a(base);
            check("stall_stability", 32'(stab_err), 32'd0);
        end

        // Stray readdatavalid while idle
        last_id = mem1;
        last_ts = mem0;
        stray_en = 1'b1;
        repeat (2) @(negedge clk);
        stray_en = 1'b0;
        @(negedge clk);
        check("idle_stray_id", id_a, last_id);
        check("idle_stray_ts", ts_a, last_ts);
        check("idle_stray_busy", 32'(busy_a), 32'd0);
        check("idle_stray_done", 32'(done_a), 32'd1);

        // Reset while waiting for the timestamp response
        mem1 = EXP_ID; mem0 = EXP_TS;
        stall_id = 0; stall_ts = 0; lat_id = 0; lat_ts = 3;
        base = acc_cnt;
        @(negedge clk) start_a = 1'b1;
        @(negedge clk) start_a = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (acc_cnt == base + 2) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ts_accept_seen", 32'(ok), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        stray_en = 1'b1;
        @(negedge clk);
        check("mid_rst_read", 32'(read_a), 32'd0);
        check("mid_rst_address", 32'(address_a), 32'd0);
        check("mid_rst_busy", 32'(busy_a), 32'd0);
        check("mid_rst_flags", {28'd0, done_a, ok_a, mism_a, tmo_a}, 32'd0);
        @(negedge clk);
        check("mid_rst_id", id_a, 32'd0);
        check("mid_rst_ts", ts_a, 32'd0);
        stray_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("rearm_busy", 32'(busy_a), 32'd1);
        check("rearm_read_id", {30'd0, read_a, address_a}, 32'b11);
        wait_idle_a(60, ok);
        check("rearm_finished", 32'(ok), 32'd1);
        check("rearm_id_ok", 32'(ok_a), 32'd1);
        check("rearm_id_value", id_a, EXP_ID);
        check("rearm_ts_value", ts_a, EXP_TS);
        check("stall_stability_end", 32'(stab_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
